// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: walks mepc/mcause/mstatus writes for ecall (and
// optionally external interrupts), mstatus restore for mret, then redirects fetch.
// Optional feature macro: TRAP_CTRL_IRQ_EN adds the irq_in port and interrupt entry.
module trap_ctrl #(
  parameter logic [31:0] ECALL_CAUSE = 32'd11,
  parameter logic [31:0] IRQ_CAUSE   = 32'h8000000B
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_req,
  input  logic        mret_req,
  input  logic [31:0] cur_pc,
`ifdef TRAP_CTRL_IRQ_EN
  input  logic        irq_in,
`endif
  input  logic [31:0] csr_mstatus,
  input  logic [31:0] csr_mtvec,
  input  logic [31:0] csr_mepc,
  output logic        csr_wen,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  typedef enum logic [2:0] {
    IDLE,
    T_EPC,
    T_CAUSE,
    T_STAT,
    M_STAT,
    REDIR
  } state_t;

  state_t      state;
  logic [31:0] cause_q;
  logic        irq_take;

`ifdef TRAP_CTRL_IRQ_EN
  assign irq_take = irq_in & csr_mstatus[3];
`else
  assign irq_take = 1'b0;
`endif

  // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= M.
  function automatic logic [31:0] trap_mstatus(input logic [31:0] m);
    logic [31:0] r;
    r        = m;
    r[7]     = m[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // Trap return: MIE <= MPIE, MPIE <= 1, MPP stays M (machine-only core).
  function automatic logic [31:0] mret_mstatus(input logic [31:0] m);
    logic [31:0] r;
    r        = m;
    r[3]     = m[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // Outputs are registered alongside the state they belong to, so each
  // transition loads the strobe/data the destination state presents.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cause_q        <= '0;
      csr_wen        <= 1'b0;
      csr_waddr      <= '0;
      csr_wdata      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      busy           <= 1'b0;
    end else begin
      csr_wen        <= 1'b0;
      csr_waddr      <= '0;
      csr_wdata      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      case (state)
        IDLE: begin
          if (trap_req) begin
            state     <= T_EPC;
            cause_q   <= ECALL_CAUSE;
            busy      <= 1'b1;
            csr_wen   <= 1'b1;
            csr_waddr <= ADDR_MEPC;
            csr_wdata <= cur_pc;
          end else if (mret_req) begin
            state     <= M_STAT;
            busy      <= 1'b1;
            csr_wen   <= 1'b1;
            csr_waddr <= ADDR_MSTATUS;
            csr_wdata <= mret_mstatus(csr_mstatus);
          end else if (irq_take) begin
            state     <= T_EPC;
            cause_q   <= IRQ_CAUSE;
            busy      <= 1'b1;
            csr_wen   <= 1'b1;
            csr_waddr <= ADDR_MEPC;
            csr_wdata <= cur_pc;
          end else begin
            busy <= 1'b0;
          end
        end
        T_EPC: begin
          state     <= T_CAUSE;
          csr_wen   <= 1'b1;
          csr_waddr <= ADDR_MCAUSE;
          csr_wdata <= cause_q;
        end
        T_CAUSE: begin
          state     <= T_STAT;
          csr_wen   <= 1'b1;
          csr_waddr <= ADDR_MSTATUS;
          csr_wdata <= trap_mstatus(csr_mstatus);
        end
        T_STAT: begin
          state          <= REDIR;
          redirect_valid <= 1'b1;
          redirect_pc    <= csr_mtvec & ~32'd3;
        end
        M_STAT: begin
          state          <= REDIR;
          redirect_valid <= 1'b1;
          redirect_pc    <= csr_mepc;
        end
        REDIR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios plus randomized traffic against a
// sequence-table reference model. Define TRAP_CTRL_IRQ_EN to cover interrupts.
module tb_trap_ctrl;

  typedef struct packed {
    logic        wen;
    logic [11:0] addr;
    logic [31:0] data;
    logic        rv;
    logic [31:0] rpc;
    logic        busy;
  } out_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        trap_req = 1'b0;
  logic        mret_req = 1'b0;
  logic [31:0] cur_pc = '0;
  logic        irq_in = 1'b0;
  logic [31:0] csr_mstatus = '0;
  logic [31:0] csr_mtvec = '0;
  logic [31:0] csr_mepc = '0;
  logic        csr_wen;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  int checks = 0;
  int errors = 0;

  out_t obs;
  out_t cur;
  out_t q[$];

  assign obs = {csr_wen, csr_waddr, csr_wdata, redirect_valid, redirect_pc, busy};

  trap_ctrl dut (
    .clk(clk),
    .rst(rst),
    .trap_req(trap_req),
    .mret_req(mret_req),
    .cur_pc(cur_pc),
`ifdef TRAP_CTRL_IRQ_EN
    .irq_in(irq_in),
`endif
    .csr_mstatus(csr_mstatus),
    .csr_mtvec(csr_mtvec),
    .csr_mepc(csr_mepc),
    .csr_wen(csr_wen),
    .csr_waddr(csr_waddr),
    .csr_wdata(csr_wdata),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic out_t mk(input logic wen, input logic [11:0] a, input logic [31:0] d,
                              input logic rv, input logic [31:0] rpc, input logic b);
    out_t o;
    o.wen = wen; o.addr = a; o.data = d; o.rv = rv; o.rpc = rpc; o.busy = b;
    return o;
  endfunction

  // Expected per-cycle outputs of a whole trap entry, queued at acceptance.
  task automatic push_trap(input logic [31:0] cause);
    logic [31:0] ms;
    ms = (csr_mstatus & ~32'h0000_0088) | ({31'd0, csr_mstatus[3]} << 7) | 32'h0000_1800;
    q.push_back(mk(1'b1, 12'h341, cur_pc, 1'b0, 32'd0, 1'b1));
    q.push_back(mk(1'b1, 12'h342, cause, 1'b0, 32'd0, 1'b1));
    q.push_back(mk(1'b1, 12'h300, ms, 1'b0, 32'd0, 1'b1));
    q.push_back(mk(1'b0, 12'h000, 32'd0, 1'b1, {csr_mtvec[31:2], 2'b00}, 1'b1));
  endtask

  task automatic push_mret();
    logic [31:0] ms;
    ms = (csr_mstatus & ~32'h0000_0008) | ({31'd0, csr_mstatus[7]} << 3) | 32'h0000_1880;
    q.push_back(mk(1'b1, 12'h300, ms, 1'b0, 32'd0, 1'b1));
    q.push_back(mk(1'b0, 12'h000, 32'd0, 1'b1, csr_mepc, 1'b1));
  endtask

  // Drive one cycle of inputs, advance the model at the edge, sample 1ns later.
  task automatic tick(input logic t, input logic m, input logic irq, input logic r);
    logic irq_eff;
`ifdef TRAP_CTRL_IRQ_EN
    irq_eff = irq;
`else
    irq_eff = 1'b0;
`endif
    trap_req = t; mret_req = m; irq_in = irq; rst = r;
    @(posedge clk);
    if (r) begin
      q.delete();
      cur = '0;
    end else begin
      if (!cur.busy) begin
        if (t) push_trap(32'd11);
        else if (m) push_mret();
        else if (irq_eff && csr_mstatus[3]) push_trap(32'h8000000B);
      end
      if (q.size() > 0) cur = q.pop_front();
      else cur = '0;
    end
    #1;
    trap_req = 1'b0; mret_req = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs !== out_t'(0)) begin
      errors++;
      $display("FAIL reset_state got=%h want=%h", obs, out_t'(0));
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_trap();
    out_t exp_tab[5];
    csr_mstatus = 32'h1808; csr_mtvec = 32'h80000101; cur_pc = 32'h80000010;
    exp_tab[0] = mk(1'b1, 12'h341, 32'h80000010, 1'b0, 32'd0, 1'b1);
    exp_tab[1] = mk(1'b1, 12'h342, 32'd11, 1'b0, 32'd0, 1'b1);
    exp_tab[2] = mk(1'b1, 12'h300, 32'h1880, 1'b0, 32'd0, 1'b1);
    exp_tab[3] = mk(1'b0, 12'h000, 32'd0, 1'b1, 32'h80000100, 1'b1);
    exp_tab[4] = '0;
    for (int i = 0; i < 5; i++) begin
      tick(i == 0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (obs !== exp_tab[i]) begin
        errors++;
        $display("FAIL trap_seq[%0d] got=%h want=%h", i, obs, exp_tab[i]);
      end
    end
  endtask

  task automatic test_mret();
    out_t exp_tab[3];
    csr_mstatus = 32'h1880; csr_mepc = 32'h80000014;
    exp_tab[0] = mk(1'b1, 12'h300, 32'h1888, 1'b0, 32'd0, 1'b1);
    exp_tab[1] = mk(1'b0, 12'h000, 32'd0, 1'b1, 32'h80000014, 1'b1);
    exp_tab[2] = '0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, i == 0, 1'b0, 1'b0);
      checks++;
      if (obs !== exp_tab[i]) begin
        errors++;
        $display("FAIL mret_seq[%0d] got=%h want=%h", i, obs, exp_tab[i]);
      end
    end
  endtask

  // Simultaneous trap+mret, then requests fired at every busy cycle.
  task automatic test_back_to_back();
    csr_mstatus = 32'h0000_1808; csr_mtvec = 32'h0000_4000; csr_mepc = 32'h0000_9000;
    cur_pc = 32'h0000_1234;
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (csr_waddr !== 12'h341 || csr_wdata !== 32'h0000_1234) begin
      errors++;
      $display("FAIL collision_first got=%h/%h want=341/00001234", csr_waddr, csr_wdata);
    end
    for (int i = 0; i < 4; i++) begin
      cur_pc = 32'hDEAD_0000 + i;
      tick(i[0], !i[0], 1'b0, 1'b0);
      checks++;
      if (obs !== cur) begin
        errors++;
        $display("FAIL busy_ignore[%0d] got=%h want=%h", i, obs, cur);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_seq got=%b want=0", busy);
    end
  endtask

  task automatic test_reset_mid();
    csr_mstatus = 32'h0000_1808; csr_mtvec = 32'h0000_2000; cur_pc = 32'h0000_0400;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (csr_waddr !== 12'h342) begin
      errors++;
      $display("FAIL reset_mid_setup got=%h want=342", csr_waddr);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== out_t'(0)) begin
        errors++;
        $display("FAIL reset_mid[%0d] got=%h want=%h", i, obs, out_t'(0));
      end
      tick(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

`ifdef TRAP_CTRL_IRQ_EN
  task automatic test_irq();
    csr_mstatus = 32'h1800; cur_pc = 32'h80000200; csr_mtvec = 32'h8000_0000;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (obs !== out_t'(0)) begin
        errors++;
        $display("FAIL irq_masked[%0d] got=%h want=0", i, obs);
      end
    end
    csr_mstatus = 32'h1808;
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (csr_waddr !== 12'h341 || csr_wdata !== 32'h80000200) begin
      errors++;
      $display("FAIL irq_mepc got=%h/%h want=341/80000200", csr_waddr, csr_wdata);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (csr_waddr !== 12'h342 || csr_wdata !== 32'h8000000B) begin
      errors++;
      $display("FAIL irq_mcause got=%h/%h want=342/8000000b", csr_waddr, csr_wdata);
    end
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (!cur.busy) begin
        csr_mstatus = $urandom;
        csr_mtvec   = $urandom;
        csr_mepc    = $urandom;
      end
      cur_pc = $urandom;
      tick($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0);
      checks++;
      if (obs !== cur) begin
        errors++;
        $display("FAIL random[%0d] got=%h want=%h", i, obs, cur);
      end
    end
  endtask

  initial begin
    cur = '0;
    test_reset();
    test_trap();
    test_mret();
    test_back_to_back();
    test_reset_mid();
`ifdef TRAP_CTRL_IRQ_EN
    test_irq();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter ECALL_CAUSE, default 32'd11, mcause value written for an ecall trap.
REQ-002 SHALL have parameter IRQ_CAUSE, default 32'h8000000B, mcause value written for an external interrupt.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port trap_req  input  1  one-cycle pulse, ecall retiring.
REQ-006 SHALL have port mret_req  input  1  one-cycle pulse, mret retiring.
REQ-007 SHALL have port cur_pc  input  32  PC of the retiring or next instruction.
REQ-008 SHALL have port irq_in  input  1  level external interrupt; present only with TRAP_CTRL_IRQ_EN.
REQ-009 SHALL have port csr_mstatus / csr_mtvec / csr_mepc  input  32 each  current CSR file values.
REQ-010 SHALL have port csr_wen  output  1  CSR write strobe.
REQ-011 SHALL have port csr_waddr  output  12  CSR address: 0x300, 0x341 or 0x342.
REQ-012 SHALL have port csr_wdata  output  32  CSR write data.
REQ-013 SHALL have port redirect_valid  output  1  one-cycle pulse, fetch jumps to redirect_pc.
REQ-014 SHALL have port redirect_pc  output  32  jump target.
REQ-015 SHALL have port busy  output  1  high whenever state != IDLE; core stalls issue.

Function
REQ-016 SHALL implement FSM states IDLE, T_EPC, T_CAUSE, T_STAT, M_STAT, REDIR; one CSR write per cycle max.
REQ-017 In IDLE, trap_req SHALL latch cur_pc and ECALL_CAUSE, next state T_EPC.
REQ-018 In IDLE, mret_req without trap_req SHALL go to M_STAT.
REQ-019 Priority in IDLE: trap_req > mret_req > irq; lower-priority events in the same cycle are dropped (irq, being level, is retaken later).
REQ-020 T_EPC: csr_wen=1, waddr 0x341, wdata latched pc; next T_CAUSE.
REQ-021 T_CAUSE: csr_wen=1, waddr 0x342, wdata latched cause; next T_STAT.
REQ-022 T_STAT: csr_wen=1, waddr 0x300, wdata = csr_mstatus with bit7(MPIE)=bit3(MIE), bit3=0, bits12:11=2'b11; next REDIR.
REQ-023 M_STAT: csr_wen=1, waddr 0x300, wdata = csr_mstatus with bit3=bit7, bit7=1, bits12:11=2'b11; next REDIR.
REQ-024 REDIR: redirect_valid=1 for exactly one cycle; redirect_pc = {csr_mtvec[31:2],2'b00} for trap/irq, csr_mepc for mret; next IDLE.
REQ-025 Latency: trap request at edge N -> writes at N+1, N+2, N+3, redirect at N+4; mret at N -> write N+1, redirect N+2.
REQ-026 trap_req, mret_req, irq_in SHALL be ignored while busy=1.
REQ-027 In all non-write states csr_wen=0; csr_waddr/csr_wdata SHALL be 0 when csr_wen=0.
REQ-028 redirect_pc SHALL be 0 when redirect_valid=0.

Reset
REQ-029 rst=1 at any edge SHALL force IDLE, clear latched pc/cause, all outputs 0 next cycle, including mid-sequence; no partial sequence resumes.
REQ-030 Reset values: csr_wen=0, csr_waddr=0, csr_wdata=0, redirect_valid=0, redirect_pc=0, busy=0.

Configuration
REQ-031 Macro TRAP_CTRL_IRQ_EN defined: irq_in exists; in IDLE with irq_in=1, csr_mstatus[3]=1 and no trap_req/mret_req, latch cur_pc and IRQ_CAUSE and go to T_EPC.
REQ-032 Macro undefined: no irq_in port, interrupts never taken, all other behaviour identical.

Verification
REQ-033 trap_req pulse, cur_pc=0x80000010, mstatus=0x1808, mtvec=0x80000101 -> writes 0x341<=0x80000010, 0x342<=11, 0x300<=0x1880, then redirect 0x80000100 at N+4.
REQ-034 mret_req, mstatus=0x1880, mepc=0x80000014 -> 0x300<=0x1888 at N+1, redirect 0x80000014 at N+2, busy low N+3.
REQ-035 trap_req and mret_req same cycle -> trap sequence only; second request while busy -> no effect.
REQ-036 rst asserted in T_CAUSE -> next cycle IDLE, csr_wen=0, no mstatus write, no redirect.
REQ-037 IRQ_EN: irq_in=1, mstatus=0x1808, cur_pc=0x80000200 -> mcause<=0x8000000B, mepc<=0x80000200; with mstatus[3]=0 -> no action.
